// File: rtl/core_lsu.sv
// Load/store unit: one single-beat req/ack data-memory access per start, with
// lane steering, byte strobes, load extension and a bounded wait for ack.
module core_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        i_lb,
  input  logic        i_lh,
  input  logic        i_lw,
  input  logic        i_lbu,
  input  logic        i_lhu,
  input  logic        i_sb,
  input  logic        i_sh,
  input  logic        i_sw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  ld_op_q, ld_op_d;  // {lb, lh, lw, lbu, lhu}; all zero for stores
  logic [1:0]  off_q, off_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] load_data_q, load_data_d;

  logic [7:0]  ops;
  logic        misaligned;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] ext_data;

  assign ops        = {i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw};
  assign misaligned = ((i_lh | i_lhu | i_sh) & addr[0]) | ((i_lw | i_sw) & (|addr[1:0]));

  // Byte lane comes from a shift by the latched offset; halves are only at 0 or 2.
  assign rd_shift = mem_rdata >> {off_q, 3'b000};
  assign rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ext_data = 32'h0;
    unique case (1'b1)
      ld_op_q[4]: ext_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      ld_op_q[3]: ext_data = {{16{rd_half[15]}}, rd_half};
      ld_op_q[2]: ext_data = mem_rdata;
      ld_op_q[1]: ext_data = {24'h0, rd_shift[7:0]};
      ld_op_q[0]: ext_data = {16'h0, rd_half};
      default:    ext_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_op_d     = ld_op_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = 8'd0;
          if (!$onehot(ops)) begin
            state_d = S_DONE;
            err_d   = 2'b11;
          end else if (misaligned) begin
            state_d = S_DONE;
            err_d   = 2'b01;
          end else begin
            state_d     = S_REQ;
            ld_op_d     = {i_lb, i_lh, i_lw, i_lbu, i_lhu};
            off_d       = addr[1:0];
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_we_d    = i_sb | i_sh | i_sw;
            mem_wstrb_d = i_sb ? (4'b0001 << addr[1:0]) :
                          i_sh ? (4'b0011 << addr[1:0]) :
                          i_sw ? 4'b1111 : 4'b0000;
            mem_wdata_d = i_sb ? {4{wdata[7:0]}} :
                          i_sh ? {2{wdata[15:0]}} :
                          i_sw ? wdata : 32'h0;
          end
        end
      end
      S_REQ: begin
        // Ack has priority over an expiring count on the same edge.
        if (mem_ack) begin
          state_d     = S_DONE;
          err_d       = 2'b00;
          load_data_d = ext_data;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      ld_op_q     <= 5'd0;
      off_q       <= 2'd0;
      mem_addr_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
      err_q       <= 2'b00;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_op_q     <= ld_op_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_req   = (state_q == S_REQ);
  assign err       = err_q;
  assign load_data = load_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_core_lsu.sv
// Directed table-driven bench for core_lsu plus hand sequences for reset and DONE-state start.
module tb_core_lsu;
  localparam logic [7:0] OP_LB = 8'h80, OP_LH = 8'h40, OP_LW = 8'h20, OP_LBU = 8'h10;
  localparam logic [7:0] OP_LHU = 8'h08, OP_SB = 8'h04, OP_SH = 8'h02, OP_SW = 8'h01;
  localparam int NEVER = 255;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic i_lb = 0, i_lh = 0, i_lw = 0, i_lbu = 0, i_lhu = 0, i_sb = 0, i_sh = 0, i_sw = 0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic busy, done, mem_req, mem_we;
  logic [1:0] err;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;

  int errors = 0, checks = 0;

  core_lsu #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .i_lb(i_lb), .i_lh(i_lh), .i_lw(i_lw), .i_lbu(i_lbu), .i_lhu(i_lhu),
    .i_sb(i_sb), .i_sh(i_sh), .i_sw(i_sw),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // wait cycles before ack, NEVER = no ack
    logic [1:0]  err;
    logic        chk_ld;
    logic [31:0] ld;
    logic [31:0] maddr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] mwd;
    int          edges;   // edges from start edge (counted as 1) to done visible
    int          reqc;    // cycles with mem_req high
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [7:0] op);
    {i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw} = op;
  endtask

  task automatic run_vec(input vec_t v);
    int n, reqc;
    bit seen_done;
    n = 1; reqc = 0; seen_done = 0;
    @(negedge clk);
    start = 1'b1; drive_op(v.op); addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 start = 1'b0; drive_op(8'h00); addr = 32'hFFFF_FFFF; wdata = 32'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin seen_done = 1; break; end
      if (mem_req) begin
        if (reqc == 0) begin
          check({v.name, " mem_addr"}, mem_addr, v.maddr);
          check({v.name, " mem_we"}, {31'h0, mem_we}, {31'h0, v.we});
          check({v.name, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, v.strb});
          if (v.we) check({v.name, " mem_wdata"}, mem_wdata, v.mwd);
        end
        mem_ack = (reqc == v.delay);
        mem_rdata = v.rdata;
        reqc++;
      end
      @(posedge clk);
      #1 mem_ack = 1'b0; mem_rdata = 32'h0;
      n++;
    end
    check({v.name, " done_seen"}, {31'h0, seen_done}, 32'h1);
    check({v.name, " done_edges"}, n, v.edges);
    check({v.name, " req_cycles"}, reqc, v.reqc);
    check({v.name, " err"}, {30'h0, err}, {30'h0, v.err});
    if (v.chk_ld) check({v.name, " load_data"}, load_data, v.ld);
    @(negedge clk);
    check({v.name, " after done/busy"}, {30'h0, done, busy}, 32'h0);
    check({v.name, " err held"}, {30'h0, err}, {30'h0, v.err});
    $display("vec %-10s err=%b load_data=%h edges=%0d req_cycles=%0d", v.name, err, load_data, n, reqc);
  endtask

  initial begin
    vecs[0]  = '{"lw_wait2", OP_LW, 32'h104, 32'h0, 32'hDEAD_BEEF, 2, 2'b00, 1, 32'hDEAD_BEEF, 32'h104, 0, 4'h0, 32'h0, 4, 3};
    vecs[1]  = '{"lb_sx", OP_LB, 32'h203, 32'h0, 32'h80AA_BBCC, 0, 2'b00, 1, 32'hFFFF_FF80, 32'h200, 0, 4'h0, 32'h0, 2, 1};
    vecs[2]  = '{"lbu_zx", OP_LBU, 32'h203, 32'h0, 32'h80AA_BBCC, 0, 2'b00, 1, 32'h0000_0080, 32'h200, 0, 4'h0, 32'h0, 2, 1};
    vecs[3]  = '{"sh_hi", OP_SH, 32'h12, 32'h1234_5678, 32'h0, 0, 2'b00, 0, 32'h0, 32'h10, 1, 4'b1100, 32'h5678_5678, 2, 1};
    vecs[4]  = '{"lw_mis", OP_LW, 32'h6, 32'h0, 32'h0, 0, 2'b01, 0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 1, 0};
    vecs[5]  = '{"ill_2op", OP_LB | OP_SW, 32'h0, 32'h0, 32'h0, 0, 2'b11, 0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 1, 0};
    vecs[6]  = '{"ill_none", 8'h00, 32'h0, 32'h0, 32'h0, 0, 2'b11, 0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 1, 0};
    vecs[7]  = '{"lh_sx", OP_LH, 32'h302, 32'h0, 32'h8001_1234, 1, 2'b00, 1, 32'hFFFF_8001, 32'h300, 0, 4'h0, 32'h0, 3, 2};
    vecs[8]  = '{"lhu_zx", OP_LHU, 32'h300, 32'h0, 32'h8001_F234, 0, 2'b00, 1, 32'h0000_F234, 32'h300, 0, 4'h0, 32'h0, 2, 1};
    vecs[9]  = '{"sw_tmo", OP_SW, 32'h20, 32'hAABB_CCDD, 32'h0, NEVER, 2'b10, 1, 32'h0000_F234, 32'h20, 1, 4'hF, 32'hAABB_CCDD, 17, 16};
    vecs[10] = '{"sw_ack16", OP_SW, 32'h24, 32'h0102_0304, 32'h0, 15, 2'b00, 0, 32'h0, 32'h24, 1, 4'hF, 32'h0102_0304, 17, 16};
    vecs[11] = '{"sb_b1", OP_SB, 32'h401, 32'h0000_00A5, 32'h0, 0, 2'b00, 0, 32'h0, 32'h400, 1, 4'b0010, 32'hA5A5_A5A5, 2, 1};
    vecs[12] = '{"lh_mis", OP_LH, 32'h3, 32'h0, 32'h0, 0, 2'b01, 0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 1, 0};
    vecs[13] = '{"sw_mis", OP_SW, 32'h2, 32'h0, 32'h0, 0, 2'b01, 0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 1, 0};

    #3;
    check("reset ctl", {27'h0, busy, done, mem_req, mem_we, 1'b0}, 32'h0);
    check("reset err/strb", {26'h0, err, mem_wstrb}, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset load_data", load_data, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Start held through DONE must not launch a second access.
    @(negedge clk);
    start = 1'b1; drive_op(OP_LW); addr = 32'h6;
    @(posedge clk);
    #1 drive_op(OP_LB); addr = 32'h40;
    @(negedge clk);
    check("done_start done", {31'h0, done}, 32'h1);
    @(posedge clk);
    #1 start = 1'b0; drive_op(8'h00);
    @(negedge clk);
    check("done_start ignored", {30'h0, busy, mem_req}, 32'h0);
    $display("seq done_start busy=%b mem_req=%b", busy, mem_req);

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    start = 1'b1; drive_op(OP_LW); addr = 32'h100;
    @(posedge clk);
    #1 start = 1'b0; drive_op(8'h00);
    @(negedge clk);
    check("rst_mid req before", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid drop", {29'h0, mem_req, busy, done}, 32'h0);
    check("rst_mid mem_addr", mem_addr, 32'h0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid no done", {30'h0, done, busy}, 32'h0);
    end
    $display("seq rst_mid mem_req=%b busy=%b done=%b", mem_req, busy, done);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
